// File: rtl/ip_update_pkg.sv
// rtl/ip_update_pkg.sv - shared types and code maps for the ip update arbiter
package ip_update_pkg;

   typedef logic [1:0] ip_t;

   typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;

   typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

   // requester A steps the pointer forward: ip = code + 1 mod 4
   function automatic ip_t map_a(input ip_t code);
      return code + 2'd1;
   endfunction

   // requester B mirrors the code: ip = 3 - code mod 4
   function automatic ip_t map_b(input ip_t code);
      return 2'd3 - code;
   endfunction

endpackage

// File: rtl/ip_req_buffer.sv
// rtl/ip_req_buffer.sv - one-entry valid/ready holding buffer for an ip update code
module ip_req_buffer
   import ip_update_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic valid,
   input  ip_t  code_in,
   output logic ready,
   input  logic clear,
   output logic full,
   output ip_t  code
);

   // ready depends only on the stored flag, never on valid
   assign ready = !full;

   // capture a code when empty; the arbiter clears it on grant (only ever while full)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         full <= 1'b0;
         code <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (valid && !full) begin
         full <= 1'b1;
         code <= code_in;
      end
   end

endmodule

// File: rtl/ip_update_arbiter.sv
// rtl/ip_update_arbiter.sv - round-robin single writer of ip from two request streams (option: IP_UPDATE_CONFLICT_CNT_EN)
module ip_update_arbiter
   import ip_update_pkg::*;
#(
   parameter ip_t IP_RESET  = 2'd0,
   parameter int  CNT_WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 a_valid,
   input  logic [1:0]           a_in,
   output logic                 a_ready,
   input  logic                 b_valid,
   input  logic [1:0]           b_in,
   output logic                 b_ready,
   output logic [1:0]           ip,
   output logic                 commit,
   output logic                 commit_src,
   output logic [CNT_WIDTH-1:0] conflicts
);

   logic a_full, b_full;
   ip_t  a_code, b_code;
   logic grant_a, grant_b;
   pri_t pri_q, pri_d;
   src_t src_q;

   ip_req_buffer u_buf_a (
      .clock   (clock),
      .reset   (reset),
      .valid   (a_valid),
      .code_in (a_in),
      .ready   (a_ready),
      .clear   (grant_a),
      .full    (a_full),
      .code    (a_code)
   );

   ip_req_buffer u_buf_b (
      .clock   (clock),
      .reset   (reset),
      .valid   (b_valid),
      .code_in (b_in),
      .ready   (b_ready),
      .clear   (grant_b),
      .full    (b_full),
      .code    (b_code)
   );

   // priority pointer register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) pri_q <= PRI_A;
      else       pri_q <= pri_d;
   end

   // grant a lone request, or the priority holder on collision; priority then passes to the other port
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      pri_d   = pri_q;
      case (pri_q)
         PRI_A: begin
            if (a_full)      grant_a = 1'b1;
            else if (b_full) grant_b = 1'b1;
         end
         PRI_B: begin
            if (b_full)      grant_b = 1'b1;
            else if (a_full) grant_a = 1'b1;
         end
         default: ;
      endcase
      if (grant_a) pri_d = PRI_B;
      if (grant_b) pri_d = PRI_A;
   end

   // commit the granted code into ip; ip and source only move on commit edges
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ip     <= IP_RESET;
         commit <= 1'b0;
         src_q  <= SRC_A;
      end else begin
         commit <= grant_a || grant_b;
         if (grant_a) begin
            ip    <= map_a(a_code);
            src_q <= SRC_A;
         end else if (grant_b) begin
            ip    <= map_b(b_code);
            src_q <= SRC_B;
         end
      end
   end

   assign commit_src = src_q;

`ifdef IP_UPDATE_CONFLICT_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q;

   // count cycles with both buffers full, holding at all-ones
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                               cnt_q <= '0;
      else if (a_full && b_full && !(&cnt_q))  cnt_q <= cnt_q + 1'b1;
   end

   assign conflicts = cnt_q;
`else
   assign conflicts = '0;
`endif

endmodule

// File: tb/tb_ip_update_arbiter.sv
// tb/tb_ip_update_arbiter.sv - directed self-checking bench for ip_update_arbiter (option: IP_UPDATE_CONFLICT_CNT_EN)
module tb_ip_update_arbiter;

`ifdef IP_UPDATE_CONFLICT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       a_valid = 1'b0;
   logic [1:0] a_in = 2'd0;
   logic       a_ready;
   logic       b_valid = 1'b0;
   logic [1:0] b_in = 2'd0;
   logic       b_ready;
   logic [1:0] ip;
   logic       commit;
   logic       commit_src;
   logic [7:0] conflicts;

   int tests = 0;
   int fails = 0;

   ip_update_arbiter #(.IP_RESET(2'd2), .CNT_WIDTH(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .a_valid    (a_valid),
      .a_in       (a_in),
      .a_ready    (a_ready),
      .b_valid    (b_valid),
      .b_in       (b_in),
      .b_ready    (b_ready),
      .ip         (ip),
      .commit     (commit),
      .commit_src (commit_src),
      .conflicts  (conflicts)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      step();
      reset = 1'b0;
   endtask

   function automatic logic [1:0] ref_a(input logic [1:0] c);
      case (c)
         2'd0: return 2'd1;
         2'd1: return 2'd2;
         2'd2: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] ref_b(input logic [1:0] c);
      case (c)
         2'd0: return 2'd3;
         2'd1: return 2'd2;
         2'd2: return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   logic [1:0] qa[$];
   logic [1:0] qb[$];
   logic [1:0] exp_code;
   logic       acc_a, acc_b, exp_commit, exp_src, pri, last_src, had_commit;
   int         a_cnt, b_cnt, n_commit;

   initial begin
      // reset values
      do_reset();
      check("rst_ip", ip, 2);
      check("rst_commit", commit, 0);
      check("rst_src", commit_src, 0);
      check("rst_a_ready", a_ready, 1);
      check("rst_b_ready", b_ready, 1);
      check("rst_conflicts", conflicts, 0);

      // reset mid-request drops the buffered code
      a_valid = 1'b1; a_in = 2'd1;
      step();
      check("mid_a_full", a_ready, 0);
      a_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("mid_async_ready", a_ready, 1);
      check("mid_async_commit", commit, 0);
      step();
      reset = 1'b0;
      step();
      check("mid_no_commit", commit, 0);
      check("mid_ip_kept", ip, 2);
      check("mid_ready", a_ready, 1);

      // single A request, code 2
      a_valid = 1'b1; a_in = 2'd2;
      step();
      a_valid = 1'b0;
      check("a1_ready_low", a_ready, 0);
      check("a1_no_commit_yet", commit, 0);
      step();
      check("a1_commit", commit, 1);
      check("a1_ip", ip, 3);
      check("a1_src", commit_src, 0);
      check("a1_ready_back", a_ready, 1);
      step();
      check("a1_commit_drop", commit, 0);
      check("a1_ip_hold", ip, 3);

      // single B requests, code 0 then code 3
      b_valid = 1'b1; b_in = 2'd0;
      step();
      b_valid = 1'b0;
      step();
      check("b0_commit", commit, 1);
      check("b0_ip", ip, 3);
      check("b0_src", commit_src, 1);
      b_valid = 1'b1; b_in = 2'd3;
      step();
      b_valid = 1'b0;
      check("b3_no_commit_yet", commit, 0);
      step();
      check("b3_commit", commit, 1);
      check("b3_ip", ip, 0);
      check("b3_src", commit_src, 1);

      // collision from reset: A code 0 wins, B code 2 next cycle
      do_reset();
      a_valid = 1'b1; a_in = 2'd0;
      b_valid = 1'b1; b_in = 2'd2;
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      step();
      check("col_commit_a", commit, 1);
      check("col_ip_a", ip, 1);
      check("col_src_a", commit_src, 0);
      check("col_b_waiting", b_ready, 0);
      check("col_conflicts", conflicts, CNT_EN ? 1 : 0);
      step();
      check("col_commit_b", commit, 1);
      check("col_ip_b", ip, 1);
      check("col_src_b", commit_src, 1);
      check("col_conflicts_hold", conflicts, CNT_EN ? 1 : 0);
      step();
      check("col_idle", commit, 0);

      // both ports streaming: scoreboard with alternation check
      do_reset();
      a_cnt = 0; b_cnt = 0; n_commit = 0;
      pri = 1'b0; had_commit = 1'b0; last_src = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1;
      a_in = 2'd0; b_in = 2'd2;
      for (int cyc = 0; cyc < 24; cyc++) begin
         acc_a = a_valid && a_ready;
         acc_b = b_valid && b_ready;
         exp_commit = (qa.size() > 0) || (qb.size() > 0);
         if (qa.size() > 0 && qb.size() > 0) exp_src = pri;
         else                                exp_src = (qb.size() > 0);
         step();
         check("str_commit", commit, exp_commit);
         if (exp_commit) begin
            pri = !exp_src;
            if (exp_src) exp_code = ref_b(qb.pop_front());
            else         exp_code = ref_a(qa.pop_front());
            check("str_src", commit_src, exp_src);
            check("str_ip", ip, exp_code);
            if (had_commit) check("str_alternate", commit_src, !last_src);
            last_src = commit_src;
            n_commit++;
         end
         had_commit = commit;
         if (acc_a) begin
            qa.push_back(a_in);
            a_cnt++;
            a_in = a_in + 2'd1;
         end
         if (acc_b) begin
            qb.push_back(b_in);
            b_cnt++;
            b_in = b_in + 2'd3;
         end
         if (cyc == 19) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
         end
      end
      check("str_qa_empty", qa.size(), 0);
      check("str_qb_empty", qb.size(), 0);
      check("str_no_loss", n_commit, a_cnt + b_cnt);
      check("str_a_count", a_cnt, 10);
      check("str_b_count", b_cnt, 10);

      // 300 forced collisions: counter saturates at 255
      do_reset();
      for (int i = 0; i < 300; i++) begin
         a_valid = 1'b1; b_valid = 1'b1;
         a_in = 2'(i); b_in = 2'(i + 1);
         step();
         a_valid = 1'b0; b_valid = 1'b0;
         step();
         step();
         if (i == 99)  check("sat_100", conflicts, CNT_EN ? 100 : 0);
         if (i == 254) check("sat_255", conflicts, CNT_EN ? 255 : 0);
      end
      check("sat_final", conflicts, CNT_EN ? 255 : 0);
      check("sat_last_ip", ip, ref_b(2'(300)));
      check("sat_last_src", commit_src, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
